// File: rtl/mult_result_stage.sv
// mult_result_stage
//
// Completion stage behind the sequential Booth multiplier. The multiplier
// always computes a signed 32x32 -> 64-bit product. This stage remembers what
// was actually asked for (operands, function, destination tag). When the
// multiplier finishes, it turns the signed product into the requested 32-bit
// result and queues it for the ALU writeback path.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   issue_valid/ready request handshake toward the multiplier
//   issue_a, issue_b  operands (also driven straight to the multiplier)
//   issue_funct       00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   issue_tag         destination register id carried with the request
//   mult_product      64-bit signed product from the multiplier
//   mult_valid        one-cycle done pulse from the multiplier
//   res_valid/ready   result FIFO head handshake toward writeback
//   res_data, res_tag FIFO head contents
//   busy              a request is outstanding in the multiplier
//   spurious          one-cycle flag: done pulse arrived when none was expected

module mult_result_stage #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [31:0]      issue_a,
  input  logic [31:0]      issue_b,
  input  logic [1:0]       issue_funct,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [63:0]      mult_product,
  input  logic             mult_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy,
  output logic             spurious
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_CORR = 2'd2;

  localparam logic [1:0] F_MUL    = 2'b00;
  localparam logic [1:0] F_MULH   = 2'b01;
  localparam logic [1:0] F_MULHSU = 2'b10;
  localparam logic [1:0] F_MULHU  = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [1:0]       funct_q, funct_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [63:0]      prod_q, prod_d;
  logic             spurious_q, spurious_d;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      data_mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_q  [DEPTH];

  logic        pending;
  logic        issue_fire;
  logic        push;
  logic        pop;
  logic [31:0] hi_s;
  logic [31:0] corr_a;
  logic [31:0] corr_b;
  logic [31:0] result;

  // Pending covers both waiting for the multiplier and the correction cycle.
  // A new request is held off until the result has been written and there
  // is guaranteed room for it, so a push never meets a full FIFO.
  assign pending     = (state_q != S_IDLE);
  assign issue_ready = !pending && (count_q < DEPTH_CNT);
  assign issue_fire  = issue_valid && issue_ready;
  assign busy        = pending;
  assign spurious    = spurious_q;

  assign push = (state_q == S_CORR);
  assign pop  = (count_q != '0) && res_ready;

  assign res_valid = (count_q != '0);
  assign res_data  = data_mem_q[rd_ptr_q];
  assign res_tag   = tag_mem_q[rd_ptr_q];

  // The multiplier treats both operands as signed. Reinterpreting an operand
  // with bit 31 set as unsigned adds 2^32 times the other operand to the
  // product, so the upper half only needs the other operand added per
  // unsigned operand with its top bit set.
  always_comb begin
    hi_s   = prod_q[63:32];
    corr_a = b_q[31] ? a_q : 32'd0;
    corr_b = a_q[31] ? b_q : 32'd0;
    result = prod_q[31:0];
    case (funct_q)
      F_MUL:    result = prod_q[31:0];
      F_MULH:   result = hi_s;
      F_MULHSU: result = hi_s + corr_a;
      F_MULHU:  result = hi_s + corr_b + corr_a;
      default:  result = prod_q[31:0];
    endcase
  end

  // Sequencing: wait for the done pulse, spend one cycle correcting and
  // writing the FIFO, then go back to accepting requests. A done pulse
  // outside the wait state has no owner, so it is only flagged.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    funct_d    = funct_q;
    tag_d      = tag_q;
    prod_d     = prod_q;
    spurious_d = mult_valid && (state_q != S_WAIT);
    case (state_q)
      S_IDLE: begin
        if (issue_fire) begin
          state_d = S_WAIT;
          a_d     = issue_a;
          b_d     = issue_b;
          funct_d = issue_funct;
          tag_d   = issue_tag;
        end
      end
      S_WAIT: begin
        if (mult_valid) begin
          state_d = S_CORR;
          prod_d  = mult_product;
        end
      end
      S_CORR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      funct_q    <= '0;
      tag_q      <= '0;
      prod_q     <= '0;
      spurious_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      funct_q    <= funct_d;
      tag_q      <= tag_d;
      prod_q     <= prod_d;
      spurious_q <= spurious_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Result storage is cleared on reset so the head outputs read zero
  // until the first result arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= '0;
        tag_mem_q[i]  <= '0;
      end
    end else if (push) begin
      data_mem_q[wr_ptr_q] <= result;
      tag_mem_q[wr_ptr_q]  <= tag_q;
    end
  end

endmodule

// File: tb/tb_mult_result_stage.sv
// tb_mult_result_stage
//
// Bench for mult_result_stage. Directed vectors come from a table, a few
// hand-written sequences cover FIFO-full, spurious, hold and reset cases, and
// a randomized run compares against a behavioural model that derives results
// directly from signed/unsigned 64-bit multiplication.

module tb_mult_result_stage;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic             clk;
  logic             reset;
  logic             issue_valid;
  logic             issue_ready;
  logic [31:0]      issue_a;
  logic [31:0]      issue_b;
  logic [1:0]       issue_funct;
  logic [TAG_W-1:0] issue_tag;
  logic [63:0]      mult_product;
  logic             mult_valid;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             busy;
  logic             spurious;

  mult_result_stage #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_a      (issue_a),
    .issue_b      (issue_b),
    .issue_funct  (issue_funct),
    .issue_tag    (issue_tag),
    .mult_product (mult_product),
    .mult_valid   (mult_valid),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_tag      (res_tag),
    .busy         (busy),
    .spurious     (spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       funct;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [63:0]      product;
    logic [TAG_W-1:0] tag;
    logic [31:0]      expected;
  } vector_t;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } resEntry_t;

  int checkCount = 0;
  int passCount  = 0;

  vector_t   vecs [6];
  resEntry_t modelQ [$];

  logic [31:0]      mA, mB;
  logic [1:0]       mF;
  logic [TAG_W-1:0] mTag;
  logic             mPend, mCorr, mSpur;
  logic             fire, popNow, doPush, spurNext, capture;
  resEntry_t        headExp;

  // Reference arithmetic: interpret operands as the function requires and
  // take the matching half of the full-width product.
  function automatic logic [31:0] refResult(input logic [1:0] f,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, ss, su, uu;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ss = sa * sb;
    su = sa * ub;
    uu = ua * ub;
    case (f)
      2'b00:   return ss[31:0];
      2'b01:   return ss[63:32];
      2'b10:   return su[63:32];
      default: return uu[63:32];
    endcase
  endfunction

  // What the Booth multiplier itself would produce: signed x signed.
  function automatic logic [63:0] refProduct(input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issue one request and complete it, without popping the result.
  task automatic doOp(input logic [1:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [63:0] prod,
                      input logic [TAG_W-1:0] tag);
    issue_valid = 1'b1;
    issue_funct = f;
    issue_a     = a;
    issue_b     = b;
    issue_tag   = tag;
    tick();
    issue_valid  = 1'b0;
    mult_product = prod;
    mult_valid   = 1'b1;
    tick();
    mult_valid = 1'b0;
    tick();
  endtask

  task automatic applyStimulus(input int idx, input vector_t v);
    string p;
    p = $sformatf("vec%0d", idx);
    issue_valid = 1'b1;
    issue_funct = v.funct;
    issue_a     = v.a;
    issue_b     = v.b;
    issue_tag   = v.tag;
    tick();
    issue_valid = 1'b0;
    checkOutput({p, "_busy"}, busy, 1);
    checkOutput({p, "_issueReadyPending"}, issue_ready, 0);
    mult_product = v.product;
    mult_valid   = 1'b1;
    tick();
    mult_valid = 1'b0;
    checkOutput({p, "_resValidInCorr"}, res_valid, 0);
    tick();
    checkOutput({p, "_resValid"}, res_valid, 1);
    checkOutput({p, "_resData"}, res_data, v.expected);
    checkOutput({p, "_resTag"}, res_tag, v.tag);
    checkOutput({p, "_busyDone"}, busy, 0);
    checkOutput({p, "_issueReadyDone"}, issue_ready, 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput({p, "_drained"}, res_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{2'b00, 32'd7,        32'd6,        64'd42,                  5'd3,  32'h0000_002A};
    vecs[1] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 5'd4,  32'hFFFF_FFFE};
    vecs[2] = '{2'b11, 32'h8000_0000, 32'd2,        64'hFFFF_FFFF_0000_0000, 5'd5,  32'h0000_0001};
    vecs[3] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 5'd6,  32'h0000_0000};
    vecs[4] = '{2'b10, 32'hFFFF_FFFF, 32'd2,        64'hFFFF_FFFF_FFFF_FFFE, 5'd7,  32'hFFFF_FFFF};
    vecs[5] = '{2'b00, 32'hFFFF_FFFD, 32'd5,        64'hFFFF_FFFF_FFFF_FFF1, 5'd31, 32'hFFFF_FFF1};

    reset        = 1'b1;
    issue_valid  = 1'b0;
    issue_a      = '0;
    issue_b      = '0;
    issue_funct  = '0;
    issue_tag    = '0;
    mult_product = '0;
    mult_valid   = 1'b0;
    res_ready    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    checkOutput("rstIssueReady", issue_ready, 1);
    checkOutput("rstResValid", res_valid, 0);
    checkOutput("rstResData", res_data, 0);
    checkOutput("rstResTag", res_tag, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstSpurious", spurious, 0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(i, vecs[i]);
    end

    // Fill the FIFO with res_ready low, then drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      doOp(2'b00, 32'(i + 1), 32'd10, 64'(10 * (i + 1)), TAG_W'(10 + i));
    end
    checkOutput("fullIssueReady", issue_ready, 0);
    checkOutput("fullResValid", res_valid, 1);
    issue_valid = 1'b1;
    issue_a     = 32'd99;
    tick();
    issue_valid = 1'b0;
    checkOutput("fullIssueRejected", busy, 0);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput($sformatf("drainData%0d", i), res_data, 64'(10 * (i + 1)));
      checkOutput($sformatf("drainTag%0d", i), res_tag, 64'(10 + i));
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      checkOutput($sformatf("drainIssueReady%0d", i), issue_ready, 1);
    end
    checkOutput("drainEmpty", res_valid, 0);

    // Done pulse while idle.
    mult_valid = 1'b1;
    tick();
    mult_valid = 1'b0;
    checkOutput("idleSpurious", spurious, 1);
    checkOutput("idleSpurResValid", res_valid, 0);
    checkOutput("idleSpurBusy", busy, 0);
    tick();
    checkOutput("idleSpuriousClear", spurious, 0);

    // Issue held while pending must not disturb the latched request;
    // a done pulse held for two cycles yields one result and a spurious flag.
    issue_valid = 1'b1;
    issue_funct = 2'b00;
    issue_a     = 32'd5;
    issue_b     = 32'd5;
    issue_tag   = 5'd1;
    tick();
    issue_funct = 2'b11;
    issue_a     = 32'd9;
    issue_b     = 32'hFFFF_FFFF;
    issue_tag   = 5'd7;
    checkOutput("holdIssueReady0", issue_ready, 0);
    tick();
    checkOutput("holdIssueReady1", issue_ready, 0);
    issue_valid  = 1'b0;
    mult_product = 64'd25;
    mult_valid   = 1'b1;
    tick();
    checkOutput("holdFirstNoSpur", spurious, 0);
    tick();
    mult_valid = 1'b0;
    checkOutput("holdSecondSpur", spurious, 1);
    checkOutput("holdResData", res_data, 25);
    checkOutput("holdResTag", res_tag, 1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput("holdSingleEntry", res_valid, 0);

    // Reset while waiting with two results queued.
    doOp(2'b00, 32'd2, 32'd3, 64'd6, 5'd2);
    doOp(2'b00, 32'd4, 32'd3, 64'd12, 5'd3);
    issue_valid = 1'b1;
    issue_a     = 32'd1;
    issue_b     = 32'd1;
    tick();
    issue_valid = 1'b0;
    checkOutput("preRstBusy", busy, 1);
    checkOutput("preRstResValid", res_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midRstResValid", res_valid, 0);
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstIssueReady", issue_ready, 1);
    tick();
    reset = 1'b0;
    mult_product = 64'd1;
    mult_valid   = 1'b1;
    tick();
    mult_valid = 1'b0;
    checkOutput("postRstSpurious", spurious, 1);
    checkOutput("postRstResValid", res_valid, 0);
    checkOutput("postRstBusy", busy, 0);
    tick();
    checkOutput("postRstSpurClear", spurious, 0);

    // Randomized run against the behavioural model.
    mA = '0; mB = '0; mF = '0; mTag = '0;
    mPend = 1'b0; mCorr = 1'b0; mSpur = 1'b0;
    modelQ.delete();
    for (int c = 0; c < 3000; c++) begin
      checkOutput("rndIssueReady", issue_ready, 64'(!mPend && (modelQ.size() < DEPTH)));
      checkOutput("rndBusy", busy, 64'(mPend));
      checkOutput("rndSpurious", spurious, 64'(mSpur));
      checkOutput("rndResValid", res_valid, 64'(modelQ.size() > 0));
      if (modelQ.size() > 0) begin
        headExp = modelQ[0];
        checkOutput("rndResData", res_data, 64'(headExp.data));
        checkOutput("rndResTag", res_tag, 64'(headExp.tag));
      end

      issue_valid  = ($urandom_range(0, 1) == 1);
      issue_a      = $urandom;
      issue_b      = $urandom;
      issue_funct  = 2'($urandom_range(0, 3));
      issue_tag    = TAG_W'($urandom);
      mult_valid   = ($urandom_range(0, 9) < 3);
      res_ready    = ($urandom_range(0, 9) < 6);
      mult_product = refProduct(mA, mB);

      fire     = issue_valid && !mPend && (modelQ.size() < DEPTH);
      popNow   = (modelQ.size() > 0) && res_ready;
      doPush   = mCorr;
      spurNext = mult_valid && !(mPend && !mCorr);
      capture  = mPend && !mCorr && mult_valid;
      tick();

      if (popNow) begin
        void'(modelQ.pop_front());
      end
      if (doPush) begin
        modelQ.push_back('{data: refResult(mF, mA, mB), tag: mTag});
        mPend = 1'b0;
      end
      mCorr = capture;
      mSpur = spurNext;
      if (fire) begin
        mA    = issue_a;
        mB    = issue_b;
        mF    = issue_funct;
        mTag  = issue_tag;
        mPend = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mult_result_stage.md
Name: mult_result_stage

Overview:
- Downstream completion stage for the sequential Booth multiplier (32x32 signed -> 64-bit product, one operation in flight).
- Latches each issued request (operands, function, tag) when it is handed to the multiplier.
- On the multiplier's done pulse, captures the 64-bit product, applies signedness correction and half-select, and queues the 32-bit result in a small FIFO.
- The FIFO feeds the ALU writeback path through a valid/ready interface.

Parameters:
- DEPTH, 2: result FIFO entries; power of two, >= 2.
- TAG_W, 5: request tag width (destination register id).

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- issue_valid  input  1  upstream presents a multiply request
- issue_ready  output  1  stage can accept a request
- issue_a  input  32  operand A, same value driven to multiplier M
- issue_b  input  32  operand B, same value driven to multiplier Q
- issue_funct  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- issue_tag  input  TAG_W  request tag
- mult_product  input  64  signed product from the multiplier
- mult_valid  input  1  multiplier done, one-cycle pulse
- res_valid  output  1  FIFO head valid
- res_ready  input  1  downstream accepts the head
- res_data  output  32  result
- res_tag  output  TAG_W  tag of the result
- busy  output  1  an operation is pending in the multiplier
- spurious  output  1  one-cycle pulse: mult_valid arrived with nothing pending

Behaviour:
- Reset (asynchronous), all outputs and state cleared:
  - pending=0, FIFO empty (count=0, rd/wr pointers 0), res_valid=0, res_data=0, res_tag=0, busy=0, spurious=0.
  - issue_ready=1 after reset.
- Issue rule:
  - issue_ready = !pending && (count < DEPTH), combinational.
  - Issue fires when issue_valid && issue_ready on a clk edge: latch a, b, funct, tag; set pending=1.
  - busy = pending.
- State machine:
  - IDLE -> WAIT on issue fire.
  - WAIT -> CORR on mult_valid; capture mult_product into a register.
  - CORR -> IDLE after one cycle; corrected result written to the FIFO at the end of CORR; pending cleared in the same cycle.
- Latency:
  - mult_valid at edge N: result is written into the FIFO at edge N+1.
  - res_valid is high after edge N+1 if the FIFO was empty.
  - A new issue is accepted at edge N+2 at the earliest (issue_ready high during the cycle after CORR).
- Arithmetic (P = captured product, hi_s = P[63:32]), all additions mod 2^32:
  - MUL: P[31:0].
  - MULH: hi_s.
  - MULHSU: hi_s + (b[31] ? a : 0).
  - MULHU: hi_s + (a[31] ? b : 0) + (b[31] ? a : 0).
- FIFO:
  - Pop when res_valid && res_ready.
  - res_data/res_tag show the head entry combinationally from storage.
  - Pointers wrap modulo DEPTH.
  - Simultaneous push and pop: count unchanged; push into a full FIFO is impossible because issue is gated by count < DEPTH.
  - Pop while empty: ignored.
- Boundary conditions:
  - mult_valid in IDLE or CORR: ignored; spurious pulses for one cycle; no FIFO write.
  - mult_valid held high for more than one cycle: only the first edge in WAIT is used.
  - issue_valid held while pending: not accepted; no latch update.
  - Reset mid-operation: pending request and all FIFO contents discarded; the multiplier is reset by the same signal.

Test Plan:
- Reset, then issue MUL a=7 b=6 tag=3; drive mult_product=42 with mult_valid pulse -> one cycle later res_valid=1, res_data=0x0000002A, res_tag=3.
- MULHU a=b=0xFFFFFFFF, product=0x0000000000000001 -> res_data=0xFFFFFFFE; MULHU a=0x80000000 b=2, product=0xFFFFFFFF00000000 -> res_data=0x00000001.
- MULH a=b=0xFFFFFFFF, product=1 -> 0x00000000; MULHSU a=0xFFFFFFFF b=2, product=0xFFFFFFFFFFFFFFFE -> 0xFFFFFFFF.
- Hold res_ready=0 and complete DEPTH operations -> issue_ready stays 0 with FIFO full; raise res_ready -> results drain in order with correct tags, issue_ready returns to 1.
- Pulse mult_valid while idle -> spurious=1 for one cycle, res_valid stays 0; issue while pending -> issue_ready=0, latched operands unchanged.
- Assert reset while WAIT with two FIFO entries queued -> res_valid=0, busy=0, issue_ready=1 immediately; a later mult_valid only pulses spurious.
